// File: rtl/bram_fifo_pkg.sv
// Shared defaults and types for the block-RAM FIFO controller.
package bram_fifo_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;

  // Pointer with one extra MSB used as the wrap bit.
  typedef logic [ADDR_W:0] ptr_t;

  // Number of FIFO entries for a given RAM address width.
  function automatic int unsigned depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/fifo_ptr_ctr.sv
// Wrap-bit pointer counter: increments on inc, rolls over naturally
// from all-ones to zero, asynchronous active-high reset.
module fifo_ptr_ctr #(
  parameter int width = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [width-1:0] ptr
);

  localparam logic [width-1:0] ONE = {{(width-1){1'b0}}, 1'b1};

  // Pointer register, advances by one on each accepted transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= {width{1'b0}};
    end else if (inc) begin
      ptr <= ptr + ONE;
    end else begin
      ptr <= ptr;
    end
  end

endmodule

// File: rtl/bram_fifo_ctrl.sv
// Synchronous FIFO controller driving an external simple dual-port RAM
// with registered read data (1-cycle read latency).
// Optional feature macro: FIFO_ERR_FLAGS_EN adds sticky overflow and
// underflow outputs, cleared only by reset.
module bram_fifo_ctrl
  import bram_fifo_pkg::*;
#(
  parameter int addr_width = ADDR_W,
  parameter int data_width = DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [data_width-1:0] wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [data_width-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic [addr_width:0]   count,
  output logic                  mem_we,
  output logic [addr_width-1:0] mem_addr_w,
  output logic [data_width-1:0] mem_din,
  output logic [addr_width-1:0] mem_addr_r,
  input  logic [data_width-1:0] mem_dout
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  logic [addr_width:0] wr_ptr;
  logic [addr_width:0] rd_ptr;
  logic                wr_acc;
  logic                rd_acc;

  // A write is refused at full even if a read is accepted in the same
  // cycle; the producer simply retries. Symmetrically for reads at empty.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  fifo_ptr_ctr #(.width(addr_width + 1)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (wr_acc),
    .ptr   (wr_ptr)
  );

  fifo_ptr_ctr #(.width(addr_width + 1)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (rd_acc),
    .ptr   (rd_ptr)
  );

  // Flags come straight from the registered pointers.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[addr_width-1:0] == rd_ptr[addr_width-1:0]) &
                 (wr_ptr[addr_width] != rd_ptr[addr_width]);
  assign count = wr_ptr - rd_ptr;

  // RAM port drive. The RAM commits a write before the read address can
  // reach that location, so no write-to-read bypass is needed.
  assign mem_we     = wr_acc;
  assign mem_addr_w = wr_ptr[addr_width-1:0];
  assign mem_din    = wr_data;
  assign mem_addr_r = rd_ptr[addr_width-1:0];

  // RAM output is already registered; it lines up with rd_valid.
  assign rd_data = mem_dout;

  // rd_valid marks the cycle after an accepted read, when mem_dout holds it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  // Sticky error flags for dropped requests; only reset clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= overflow  | (wr_en & full);
      underflow <= underflow | (rd_en & empty);
    end
  end
`endif

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Self-checking bench for bram_fifo_ctrl with a behavioural RAM model.
// Read data is checked by a scoreboard: expected words are queued when a
// read is issued and popped by a monitor whenever rd_valid is high.
module tb_bram_fifo_ctrl;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = 8'h00;
  logic          rd_en = 1'b0;
  logic          full;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          empty;
  logic [AW:0]   count;
  logic          mem_we;
  logic [AW-1:0] mem_addr_w;
  logic [DW-1:0] mem_din;
  logic [AW-1:0] mem_addr_r;
  logic [DW-1:0] mem_dout;
`ifdef FIFO_ERR_FLAGS_EN
  logic          overflow;
  logic          underflow;
`endif

  int vectors = 0;
  int errors  = 0;
  logic [DW-1:0] exp_q[$];

  bram_fifo_ctrl #(.addr_width(AW), .data_width(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .empty      (empty),
    .count      (count),
    .mem_we     (mem_we),
    .mem_addr_w (mem_addr_w),
    .mem_din    (mem_din),
    .mem_addr_r (mem_addr_r),
    .mem_dout   (mem_dout)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .overflow   (overflow),
    .underflow  (underflow)
`endif
  );

  always #5 clk = ~clk;

  // Simple dual-port RAM, registered read, contents never reset.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr_w] <= mem_din;
    mem_dout <= mem[mem_addr_r];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every rd_valid cycle must match the oldest queued word.
  always @(negedge clk) begin
    if (!reset && rd_valid === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rd_valid: got data %0h, expected no valid at %0t", rd_data, $time);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          errors++;
          $display("FAIL rd_data: got %0h, expected %0h at %0t", rd_data, e, $time);
        end
      end
    end
  end

  // One clock of stimulus; push=1 queues the word the read must return.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                      input logic push, input logic [DW-1:0] e);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_full", 32'(full), 32'd0);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_mem_we", 32'(mem_we), 32'd0);
    chk("reset_addr_w", 32'(mem_addr_w), 32'd0);
    chk("reset_addr_r", 32'(mem_addr_r), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("reset_overflow", 32'(overflow), 32'd0);
    chk("reset_underflow", 32'(underflow), 32'd0);
`endif

    // Three writes, three back-to-back reads.
    step(1'b1, 8'h11, 1'b0, 1'b0, 8'h00);
    step(1'b1, 8'h22, 1'b0, 1'b0, 8'h00);
    step(1'b1, 8'h33, 1'b0, 1'b0, 8'h00);
    chk("three_count", 32'(count), 32'd3);
    chk("three_empty", 32'(empty), 32'd0);
    chk("three_addr_w", 32'(mem_addr_w), 32'd3);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'h11);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'h22);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'h33);
    chk("three_rd_valid", 32'(rd_valid), 32'd1);
    idle(1);
    chk("three_drained_empty", 32'(empty), 32'd1);
    chk("three_drained_count", 32'(count), 32'd0);
    chk("three_rd_valid_off", 32'(rd_valid), 32'd0);

    // Fill completely, try an extra write, then drain (pointers wrap).
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 8'h00);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd1024);
    wr_en = 1'b1;
    wr_data = 8'hAA;
    #1;
    chk("fill_mem_we_blocked", 32'(mem_we), 32'd0);
    step(1'b1, 8'hAA, 1'b0, 1'b0, 8'h00);
    chk("fill_extra_count", 32'(count), 32'd1024);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b1, 8'(i));
    idle(1);
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_full", 32'(full), 32'd0);
    chk("drain_addr_r", 32'(mem_addr_r), 32'd3);

    // Simultaneous read/write at count=5 for 20 cycles.
    for (int k = 0; k < 5; k++) step(1'b1, 8'hA0 + 8'(k), 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 20; k++) begin
      if (k < 5) step(1'b1, 8'hB0 + 8'(k), 1'b1, 1'b1, 8'hA0 + 8'(k));
      else       step(1'b1, 8'hB0 + 8'(k), 1'b1, 1'b1, 8'hB0 + 8'(k - 5));
      if (k == 10) chk("rw_mid_count", 32'(count), 32'd5);
    end
    chk("rw_count", 32'(count), 32'd5);
    for (int k = 15; k < 20; k++) step(1'b0, 8'h00, 1'b1, 1'b1, 8'hB0 + 8'(k));
    idle(1);
    chk("rw_drain_empty", 32'(empty), 32'd1);

    // Simultaneous at full: only the read is taken.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i) ^ 8'h3C, 1'b0, 1'b0, 8'h00);
    chk("full2_full", 32'(full), 32'd1);
    step(1'b1, 8'hEE, 1'b1, 1'b1, 8'h3C);
    chk("rw_full_count", 32'(count), 32'd1023);
    for (int i = 1; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b1, 8'(i) ^ 8'h3C);
    idle(1);
    chk("full2_drain_empty", 32'(empty), 32'd1);

    // Simultaneous at empty: only the write is taken.
    step(1'b1, 8'h77, 1'b1, 1'b0, 8'h00);
    chk("rw_empty_count", 32'(count), 32'd1);
    chk("rw_empty_no_valid", 32'(rd_valid), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'h77);
    idle(1);

    // Write-to-read latency with rd_en held high throughout.
    step(1'b1, 8'h5C, 1'b1, 1'b0, 8'h00);
    chk("lat_n1_empty", 32'(empty), 32'd0);
    chk("lat_n1_valid", 32'(rd_valid), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'h5C);
    chk("lat_n2_valid", 32'(rd_valid), 32'd1);
    chk("lat_n2_data", 32'(rd_data), 32'h5C);
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    chk("lat_n3_valid", 32'(rd_valid), 32'd0);
    idle(1);

    // Asynchronous reset mid-burst with count=7 and rd_valid=1.
    for (int k = 0; k < 8; k++) step(1'b1, 8'hC0 + 8'(k), 1'b0, 1'b0, 8'h00);
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    chk("pre_rst_count", 32'(count), 32'd7);
    chk("pre_rst_valid", 32'(rd_valid), 32'd1);
    rd_en = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_empty", 32'(empty), 32'd1);
    chk("async_rst_valid", 32'(rd_valid), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    idle(1);
    chk("post_rst_count", 32'(count), 32'd0);

`ifdef FIFO_ERR_FLAGS_EN
    // Sticky error flags.
    step(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    chk("underflow_set", 32'(underflow), 32'd1);
    chk("overflow_clear", 32'(overflow), 32'd0);
    idle(2);
    chk("underflow_sticky", 32'(underflow), 32'd1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 8'h00);
    chk("ovf_still_clear", 32'(overflow), 32'd0);
    step(1'b1, 8'hAA, 1'b0, 1'b0, 8'h00);
    chk("overflow_set", 32'(overflow), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b1, 8'h00);
    idle(2);
    chk("overflow_sticky", 32'(overflow), 32'd1);
    do_reset();
    chk("overflow_reset", 32'(overflow), 32'd0);
    chk("underflow_reset", 32'(underflow), 32'd0);
`endif

    idle(2);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
